// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit (multiplier and divider):
// FSM state encodings and iteration-counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arith_state_t;

  localparam int ARITH_WIDTH = 12;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cnt_w(ARITH_WIDTH);

endpackage

// File: rtl/multiplier.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock,
// with a saturating WIDTH-bit result and the en/Busy/Ready/Take handshake.
module multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  input  logic             Take,
  output logic [WIDTH-1:0] Res,
  output logic             Overflow,
  output logic             Busy,
  output logic             Ready
);

  localparam int CNT_BITS = cnt_w(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

  arith_state_t         state;
  logic [2*WIDTH-1:0]   a_shift;
  logic [WIDTH-1:0]     b_shift;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_BITS-1:0]  count;

  logic [2*WIDTH-1:0]   next_acc;
  logic                 next_ovf;
  logic [WIDTH-1:0]     next_res;

  // The completion edge must see the accumulator including that edge's own add.
  always_comb begin
    next_acc = acc + (b_shift[0] ? a_shift : '0);
    next_ovf = |next_acc[2*WIDTH-1:WIDTH];
    next_res = next_ovf ? {WIDTH{1'b1}} : next_acc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      Busy     <= 1'b0;
      Ready    <= 1'b0;
      Res      <= '0;
      Overflow <= 1'b0;
      count    <= '0;
      acc      <= '0;
      a_shift  <= '0;
      b_shift  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            a_shift <= {{WIDTH{1'b0}}, Multiplicand};
            b_shift <= Multiplier;
            acc     <= '0;
            count   <= '0;
            if (Multiplicand == '0 || Multiplier == '0) begin
              Res      <= '0;
              Overflow <= 1'b0;
              Ready    <= 1'b1;
              state    <= ST_DONE;
            end else begin
              Busy  <= 1'b1;
              state <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          // Dropping en mid-run abandons the operation but keeps the last result.
          if (!en) begin
            Busy  <= 1'b0;
            Ready <= 1'b0;
            state <= ST_IDLE;
          end else begin
            acc     <= next_acc;
            a_shift <= a_shift << 1;
            b_shift <= b_shift >> 1;
            count   <= count + CNT_BITS'(1);
            if (count == LAST_CNT) begin
              Res      <= next_res;
              Overflow <= next_ovf;
              Busy     <= 1'b0;
              Ready    <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (Take) begin
            Ready <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          Busy  <= 1'b0;
          Ready <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
